// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for pipe_skid_reg.
// The master side drives the payload in; the slave side is the stage.
interface pipe_skid_reg_if #(
  parameter int DATA_W  = 32,
  parameter int FIELD_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [FIELD_W-1:0] out_field;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_field
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_field
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a 2-entry skid buffer, flush,
// decoded-field tap and a saturating stall counter.
module pipe_skid_reg #(
  parameter int               DATA_W      = 32,
  parameter int               FIELD_LSB   = 26,
  parameter int               FIELD_W     = 2,
  parameter logic [DATA_W-1:0] FLUSH_VALUE = '0,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_skid_reg_if.slave   bus,
  output logic [CNT_W-1:0] stall_cnt
);

  if (FIELD_LSB + FIELD_W > DATA_W) begin : g_bad_field
    $error("pipe_skid_reg: field exceeds payload width");
  end

  // State bits are {skid_valid, out_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] skid_data;
  logic              push;
  logic              pop;
  logic              stall;

  assign push  = bus.in_valid & bus.in_ready;
  assign pop   = bus.out_valid & bus.out_ready;
  assign stall = bus.out_valid & ~bus.out_ready & ~flush;

  assign bus.out_valid = state[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= EMPTY;
      bus.in_ready  <= 1'b1;
      bus.out_data  <= '0;
      bus.out_field <= '0;
      skid_data     <= '0;
    end else if (flush) begin
      state         <= EMPTY;
      bus.in_ready  <= 1'b1;
      bus.out_data  <= FLUSH_VALUE;
      bus.out_field <= FLUSH_VALUE[FIELD_LSB +: FIELD_W];
    end else begin
      unique case (state)
        EMPTY: begin
          if (push) begin
            state         <= ONE;
            bus.out_data  <= bus.in_data;
            bus.out_field <= bus.in_data[FIELD_LSB +: FIELD_W];
          end
        end
        ONE: begin
          if (push && pop) begin
            bus.out_data  <= bus.in_data;
            bus.out_field <= bus.in_data[FIELD_LSB +: FIELD_W];
          end else if (push) begin
            state        <= FULL;
            skid_data    <= bus.in_data;
            bus.in_ready <= 1'b0;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state         <= ONE;
            bus.in_ready  <= 1'b1;
            bus.out_data  <= skid_data;
            bus.out_field <= skid_data[FIELD_LSB +: FIELD_W];
          end
        end
        default: begin
          state        <= EMPTY;
          bus.in_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_pipe_skid_reg;
  localparam int DW = 32;
  localparam int FL = 26;
  localparam int FW = 2;
  localparam int CW = 4;
  localparam logic [DW-1:0] FV = 32'h0C00_0013;
  localparam logic [FW-1:0] FVF = FV[FL +: FW];
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [CW-1:0] stall_cnt;

  pipe_skid_reg_if #(.DATA_W(DW), .FIELD_W(FW)) bus ();

  pipe_skid_reg #(
    .DATA_W(DW), .FIELD_LSB(FL), .FIELD_W(FW),
    .FLUSH_VALUE(FV), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .bus(bus), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] q[$];
  logic [DW-1:0] m_last;
  int            m_cnt;
  int            checks = 0;
  int            errors = 0;

  // Advance one edge and update the model from the inputs seen there.
  task automatic tick();
    bit pu, po;
    @(posedge clk);
    pu = bus.in_valid && (q.size() < 2);
    po = (q.size() > 0) && bus.out_ready;
    if (reset) begin
      q.delete(); m_last = '0; m_cnt = 0;
    end else if (flush) begin
      q.delete(); m_last = FV;
    end else begin
      if (q.size() > 0 && !bus.out_ready && m_cnt < CMAX)
        m_cnt++;
      if (po) void'(q.pop_front());
      if (pu) q.push_back(bus.in_data);
      if (q.size() > 0) m_last = q[0];
    end
    #1;
  endtask

  task automatic drive(bit v, logic [DW-1:0] d, bit r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; drive(0, '0, 0);
    tick(); tick();
    reset = 0;
    checks += 5;
    if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    if (bus.out_data !== '0) begin errors++;
      $display("FAIL reset_out_data got %h exp 0", bus.out_data); end
    if (bus.out_field !== '0) begin errors++;
      $display("FAIL reset_out_field got %h exp 0", bus.out_field); end
    if (stall_cnt !== '0) begin errors++;
      $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] v [3];
    logic [FW-1:0] f [3];
    v[0] = 32'h0C00_0001; v[1] = 32'h0800_0002; v[2] = 32'h0400_0003;
    f[0] = 2'd3; f[1] = 2'd2; f[2] = 2'd1;
    for (int i = 0; i < 3; i++) begin
      drive(1, v[i], 1);
      tick();
      checks += 4;
      if (bus.out_valid !== 1'b1) begin errors++;
        $display("FAIL stream_valid[%0d] got %b exp 1", i, bus.out_valid); end
      if (bus.out_data !== v[i]) begin errors++;
        $display("FAIL stream_data[%0d] got %h exp %h", i, bus.out_data, v[i]); end
      if (bus.out_field !== f[i]) begin errors++;
        $display("FAIL stream_field[%0d] got %0d exp %0d", i, bus.out_field, f[i]); end
      if (bus.in_ready !== 1'b1) begin errors++;
        $display("FAIL stream_ready[%0d] got %b exp 1", i, bus.in_ready); end
    end
    drive(0, '0, 1);
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL stream_drain got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_skid();
    drive(1, 32'h1111_1111, 0); tick();
    drive(1, 32'h2222_2222, 0); tick();
    checks += 3;
    if (bus.in_ready !== 1'b0) begin errors++;
      $display("FAIL skid_full_ready got %b exp 0", bus.in_ready); end
    if (bus.out_data !== 32'h1111_1111) begin errors++;
      $display("FAIL skid_head got %h exp 11111111", bus.out_data); end
    if (stall_cnt !== 4'd1) begin errors++;
      $display("FAIL skid_cnt1 got %0d exp 1", stall_cnt); end
    drive(0, '0, 0); tick();
    checks += 2;
    if (stall_cnt !== 4'd2) begin errors++;
      $display("FAIL skid_cnt2 got %0d exp 2", stall_cnt); end
    if (bus.out_data !== 32'h1111_1111) begin errors++;
      $display("FAIL skid_hold got %h exp 11111111", bus.out_data); end
    drive(0, '0, 1); tick();
    checks += 3;
    if (bus.out_data !== 32'h2222_2222) begin errors++;
      $display("FAIL skid_second got %h exp 22222222", bus.out_data); end
    if (bus.out_valid !== 1'b1) begin errors++;
      $display("FAIL skid_second_valid got %b exp 1", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL skid_ready_back got %b exp 1", bus.in_ready); end
    tick();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL skid_empty got %b exp 0", bus.out_valid); end
    if (bus.out_data !== 32'h2222_2222) begin errors++;
      $display("FAIL skid_last_hold got %h exp 22222222", bus.out_data); end
  endtask

  task automatic test_flush();
    int c0;
    drive(1, 32'h3333_3333, 0); tick();
    drive(1, 32'h4444_4444, 0); tick();
    c0 = m_cnt;
    flush = 1; drive(1, 32'h5555_5555, 1); tick();
    flush = 0;
    checks += 5;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL flush_valid got %b exp 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL flush_ready got %b exp 1", bus.in_ready); end
    if (bus.out_data !== FV) begin errors++;
      $display("FAIL flush_data got %h exp %h", bus.out_data, FV); end
    if (bus.out_field !== FVF) begin errors++;
      $display("FAIL flush_field got %0d exp %0d", bus.out_field, FVF); end
    if (stall_cnt !== c0[CW-1:0]) begin errors++;
      $display("FAIL flush_cnt got %0d exp %0d", stall_cnt, c0); end
    drive(0, '0, 1); tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL flush_ghost got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_saturate();
    drive(1, 32'h6666_6666, 0); tick();
    drive(0, '0, 0);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (stall_cnt !== 4'd15) begin errors++;
      $display("FAIL sat_cnt got %0d exp 15", stall_cnt); end
    flush = 1; tick(); flush = 0;
    checks++;
    if (stall_cnt !== 4'd15) begin errors++;
      $display("FAIL sat_flush got %0d exp 15", stall_cnt); end
    reset = 1; tick(); reset = 0;
    checks++;
    if (stall_cnt !== 4'd0) begin errors++;
      $display("FAIL sat_reset got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_reset_midstream();
    drive(1, 32'h7777_7777, 0); tick();
    drive(1, 32'h8888_8888, 0); tick();
    reset = 1; drive(1, 32'h9999_9999, 1); tick();
    reset = 0;
    checks += 4;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL mid_valid got %b exp 0", bus.out_valid); end
    if (bus.in_ready !== 1'b1) begin errors++;
      $display("FAIL mid_ready got %b exp 1", bus.in_ready); end
    if (bus.out_data !== '0) begin errors++;
      $display("FAIL mid_data got %h exp 0", bus.out_data); end
    if (stall_cnt !== '0) begin errors++;
      $display("FAIL mid_cnt got %0d exp 0", stall_cnt); end
    drive(0, '0, 1); tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++;
      $display("FAIL mid_survivor got %b exp 0", bus.out_valid); end
    drive(1, 32'hABCD_0123, 1); tick();
    checks++;
    if (bus.out_data !== 32'hABCD_0123) begin errors++;
      $display("FAIL mid_resume got %h exp abcd0123", bus.out_data); end
    drive(0, '0, 1); tick();
  endtask

  task automatic test_random();
    bit ev;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom,
            $urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 24) == 0);
      tick();
      flush = 0;
      ev = (q.size() > 0);
      checks += 5;
      if (bus.out_valid !== ev) begin errors++;
        $display("FAIL rnd_valid[%0d] got %b exp %b", i, bus.out_valid, ev); end
      if (bus.in_ready !== (q.size() < 2)) begin errors++;
        $display("FAIL rnd_ready[%0d] got %b exp %b", i, bus.in_ready, q.size() < 2); end
      if (bus.out_data !== m_last) begin errors++;
        $display("FAIL rnd_data[%0d] got %h exp %h", i, bus.out_data, m_last); end
      if (bus.out_field !== m_last[FL +: FW]) begin errors++;
        $display("FAIL rnd_field[%0d] got %0d exp %0d", i, bus.out_field, m_last[FL +: FW]); end
      if (stall_cnt !== m_cnt[CW-1:0]) begin errors++;
        $display("FAIL rnd_cnt[%0d] got %0d exp %0d", i, stall_cnt, m_cnt); end
    end
  endtask

  initial begin
    reset = 1; flush = 0;
    drive(0, '0, 0);
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_saturate();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
Parametrised pipeline stage register for the control pipeline, replacing the fixed-width, enable-only fetch/decode register. It adds a valid/ready handshake with a 2-entry skid buffer, so upstream can stall without a combinational ready path. It also provides a synchronous flush that inserts a bubble and a configurable decoded-field tap. A saturating stall counter supports performance debug.

Parameters:
DATA_W, 32, width of the payload (instruction word).
FIELD_LSB, 26, LSB of the field tapped to out_field (default is the addressing-mode bits [27:26]).
FIELD_W, 2, width of out_field; elaboration must fail if FIELD_LSB+FIELD_W > DATA_W.
FLUSH_VALUE, 0, payload value loaded into out_data on flush (NOP encoding).
CNT_W, 16, width of the stall counter.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
flush  input  1  synchronous squash of all held entries.
in_valid  input  1  upstream has a payload.
in_ready  output  1  registered; stage can accept this cycle.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  registered; out_data holds a valid entry.
out_ready  input  1  downstream accepts this cycle.
out_data  output  DATA_W  registered head payload.
out_field  output  FIELD_W  registered; equals out_data[FIELD_LSB +: FIELD_W].
stall_cnt  output  CNT_W  saturating count of backpressure cycles.

Behaviour:
- Transfers: push = in_valid & in_ready; pop = out_valid & out_ready. All state updates on the rising edge of clk.
- Reset (reset=1, sampled at the edge; has priority over everything):
  - out_valid=0, in_ready=1, out_data=0, out_field=0, stall_cnt=0.
  - Skid entry is invalid and zeroed.
- Flush (reset=0, flush=1):
  - out_valid=0, skid invalid, in_ready=1.
  - out_data=FLUSH_VALUE; out_field is taken from FLUSH_VALUE.
  - A push or pop in the same cycle is discarded and has no effect.
  - stall_cnt is not cleared.
- State machine, encoded by {skid_valid, out_valid}:
  - EMPTY (0,0): push -> ONE, out<=in_data.
  - ONE (0,1):
    - push & pop -> ONE, out<=in_data.
    - push & !pop -> FULL, skid<=in_data, in_ready<=0.
    - !push & pop -> EMPTY.
    - idle -> ONE, out held.
  - FULL (1,1): in_ready=0 so no push is possible.
    - pop -> ONE, out<=skid, in_ready<=1.
    - no pop -> FULL, all held.
- in_ready equals !skid_valid and is registered, with no combinational path from out_ready.
- Ordering: strict FIFO; the skid entry is always older than any later push.
- Latency: 1 cycle from push to out_valid when EMPTY.
- Throughput: 1 payload/cycle sustained while out_ready=1.
- Stability:
  - While out_valid & !out_ready, out_data and out_field must not change.
  - When out_valid=0, out_data holds its last value (no clearing except reset/flush).
- out_field is updated in the same edge as out_data, from the same source value. It is never derived combinationally.
- stall_cnt increments by 1 on each cycle with out_valid & !out_ready & !flush. It saturates at 2^CNT_W-1 and clears only on reset.

Test Plan:
1. Reset for 2 cycles, then release -> in_ready=1, out_valid=0, out_data=0, out_field=0, stall_cnt=0.
2. Stream 0x0C000001, 0x08000002, 0x04000003 on consecutive cycles with out_ready=1 -> each appears 1 cycle after push, back-to-back, out_field=3,2,1, and in_ready stays 1.
3. Push A=0x11111111 with out_ready=0, then push B=0x22222222 -> FULL, in_ready=0 and stall_cnt counts 1,2,...
   - Raise out_ready -> A then B pop in order, and in_ready returns to 1 one cycle after the first pop.
4. In FULL, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, out_data=FLUSH_VALUE, and the flush-cycle input never appears.
5. CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt saturates at 15. Flush -> stall_cnt stays 15; reset -> stall_cnt becomes 0.
6. Assert reset mid-stream in FULL with in_valid=1 -> all outputs at reset values next cycle, no payload survives, and normal operation resumes after release.
